i2s_rx: RTL
===========

// Module: i2s_rx
// PURPOSE
// - I2S slave receiver: the capture-side counterpart of the PCM5102 I2S transmitter path.
// - Samples an external ADC's BCK/LRCK/DATA in the clk0 (48 MHz) domain.
// - Deserialises MSB-first two's-complement words and delivers one left/right pair per frame with a 1-cycle strobe.
// - Used for audio loopback and capture, e.g. DAC output -> ADC -> i2s_rx -> compare against the NCO.
// PARAMETERS
// - DATA_WIDTH  16  bits kept per channel; slot bits beyond DATA_WIDTH are ignored.
// - SYNC_STAGES 2   synchroniser flops on each of bck_i, lrck_i and din_i (legal values >= 2).
// PORTS
// - clk           in   1           system clock. clk0 of the design; must be >= 4x the BCK frequency.
// - arst          in   1           reset. Synchronous, active-high.
// - bck_i         in   1           I2S bit clock from the ADC. Asynchronous to clk.
// - lrck_i        in   1           I2S word select: 0 = left, 1 = right. Asynchronous to clk.
// - din_i         in   1           I2S serial data. Changes on BCK falling edges.
// - left          out  DATA_WIDTH  last complete left word, registered.
// - right         out  DATA_WIDTH  last complete right word, registered.
// - sample_valid  out  1           1-clk pulse when a new left/right pair is loaded.
// - locked        out  1           high once the first frame boundary has been seen.
// - slot_err      out  1           sticky flag: a slot was shorter than DATA_WIDTH bits.
// BEHAVIOUR
// - Reset (arst=1 at a clk edge): all outputs become 0, synchroniser chains are cleared, FSM goes to SYNC.
//   - Applies mid-frame; any partial word is discarded.
// - Input stage: each input passes through SYNC_STAGES flops, then one more flop for edge detection.
//   - bck_rise = synced bck is 1 and its delayed copy is 0.
//   - All capture happens only on a bck_rise cycle, using the synced lrck/din values of that cycle.
// - On each bck_rise:
//   - lr_chg = (lrck_s != lrck_prev); then lrck_prev <= lrck_s.
//   - If cnt < DATA_WIDTH: shift din_s into the shift register LSB and increment cnt (cnt saturates at DATA_WIDTH).
//   - If lr_chg: the bit sampled this edge belongs to the slot that is ending (standard I2S 1-BCK delay).
//     - Commit that slot, then clear cnt and the shift register for the new slot.
//   - Commit rule: word = shift register << (DATA_WIDTH-cnt), i.e. MSB-aligned with zero-filled LSBs.
//     - If cnt < DATA_WIDTH at commit, set slot_err.
// - FSM states: SYNC, LEFT, RIGHT.
//   - SYNC: shift and count, but never commit or set slot_err.
//     - On lr_chg with lrck_s = 0: go to LEFT and set locked = 1.
//   - LEFT: on lr_chg (lrck_s 0->1), word -> left_hold; go to RIGHT.
//   - RIGHT: on lr_chg (lrck_s 1->0), on the next clk load left <= left_hold and right <= word.
//     - Pulse sample_valid for that one clk; go to LEFT.
//   - An lr_chg toward an unexpected lrck level cannot occur: lrck is 1 bit and every lr_chg flips it.
// - Latency: sample_valid rises SYNC_STAGES+2 clk after the qualifying BCK pin rising edge (4 clk at the default).
// - left/right hold their values between pulses.
// - sample_valid never asserts on two consecutive clks.
// - The first complete pair after reset or after lock is the first one presented; any partial first frame is dropped.
// - Width: slots of any length >= 1 BCK are accepted.
//   - Longer slots (24/32 bit) are truncated to their top DATA_WIDTH bits.
//   - Shorter slots are zero-padded and raise slot_err.
// - Metastability is handled only by the synchronisers; no other clock-domain crossing exists in this block.
// TESTING
// - T1: clk 48 MHz, BCK = clk/16, 32-bit slots, L=0x1234 R=0xABCD repeated.
//   -> first pulse gives left=0x1234, right=0xABCD, slot_err=0; one pulse per 64 BCK.
// - T2: 16-bit slots, L=0x8000 R=0x7FFF.
//   -> left=0x8000, right=0x7FFF exactly; this checks the LSB bit captured at the lrck-change edge.
// - T3: release reset in mid-right-slot.
//   -> locked=0 until lrck falls; no pulse for that partial frame; the first pulse carries the next full L/R pair.
// - T4: 12-bit slots, L=0xABC (MSB-first).
//   -> left=0xABC0, slot_err=1 and stays 1 until reset.
// - T5: arst asserted for 1 clk mid-left-slot.
//   -> next clk all outputs are 0 and locked=0; the bench checks that the FSM relocks and the next pair is correct.
// - T6: BCK = clk/4, with BCK/LRCK edge jitter of +/-1 clk, over 1000 random frames.
//   -> every pair matches the scoreboard and slot_err=0.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises BCK/LRCK/DATA into the clk domain, deserialises MSB-first
// words and presents each complete left/right pair with a one-cycle sample_valid strobe.
module i2s_rx #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  bck_i,
    input  logic                  lrck_i,
    input  logic                  din_i,
    output logic [DATA_WIDTH-1:0] left,
    output logic [DATA_WIDTH-1:0] right,
    output logic                  sample_valid,
    output logic                  locked,
    output logic                  slot_err
);

    localparam int unsigned     CntW    = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);

    typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

    logic [SYNC_STAGES-1:0] bck_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   bck_s;
    logic                   lrck_s;
    logic                   din_s;
    logic                   bck_prev_q;
    logic                   lrck_prev_q;
    logic                   bck_rise;
    logic                   lr_chg;
    logic                   not_full;
    logic                   short_slot;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [DATA_WIDTH-1:0]  shreg_d;
    logic [DATA_WIDTH-1:0]  word;
    logic [DATA_WIDTH-1:0]  left_hold_q;
    logic [DATA_WIDTH-1:0]  right_hold_q;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        cnt_d;
    logic                   commit_pend_q;
    state_e                 state_q;

    assign bck_s  = bck_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign din_s  = din_sync_q[SYNC_STAGES-1];

    always_comb begin
        bck_rise   = bck_s & ~bck_prev_q;
        lr_chg     = lrck_s ^ lrck_prev_q;
        not_full   = (cnt_q < CntFull);
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        if (not_full) begin
            shreg_d = (shreg_q << 1) | DATA_WIDTH'(din_s);
            cnt_d   = cnt_q + CntW'(1);
        end
        // Short slots end up MSB-aligned with zero-filled LSBs.
        word       = shreg_d << (CntFull - cnt_d);
        short_slot = (cnt_d < CntFull);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            bck_sync_q    <= '0;
            lrck_sync_q   <= '0;
            din_sync_q    <= '0;
            bck_prev_q    <= 1'b0;
            lrck_prev_q   <= 1'b0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            left_hold_q   <= '0;
            right_hold_q  <= '0;
            commit_pend_q <= 1'b0;
            state_q       <= StSync;
            left          <= '0;
            right         <= '0;
            sample_valid  <= 1'b0;
            locked        <= 1'b0;
            slot_err      <= 1'b0;
        end else begin
            bck_sync_q    <= {bck_sync_q[SYNC_STAGES-2:0], bck_i};
            lrck_sync_q   <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_i};
            din_sync_q    <= {din_sync_q[SYNC_STAGES-2:0], din_i};
            bck_prev_q    <= bck_s;
            sample_valid  <= commit_pend_q;
            commit_pend_q <= 1'b0;
            if (commit_pend_q) begin
                left  <= left_hold_q;
                right <= right_hold_q;
            end
            if (bck_rise) begin
                lrck_prev_q <= lrck_s;
                if (lr_chg) begin
                    // The bit sampled on the lrck-change edge closes the slot that is ending.
                    shreg_q <= '0;
                    cnt_q   <= '0;
                    case (state_q)
                        StSync: begin
                            if (!lrck_s) begin
                                state_q <= StLeft;
                                locked  <= 1'b1;
                            end
                        end
                        StLeft: begin
                            left_hold_q <= word;
                            state_q     <= StRight;
                            if (short_slot) slot_err <= 1'b1;
                        end
                        StRight: begin
                            right_hold_q  <= word;
                            commit_pend_q <= 1'b1;
                            state_q       <= StLeft;
                            if (short_slot) slot_err <= 1'b1;
                        end
                        default: state_q <= StSync;
                    endcase
                end else begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                end
            end
        end
    end

endmodule
